kernel_launcher: RTL and testbench

KERNEL_LAUNCHER -- requirements
Module: kernel_launcher

---
 rtl/kernel_launcher.sv | 189 ++++++++++++++++++
 tb/tb_kernel_launcher.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_launcher.sv
// Host-driven kernel launcher: loads program memory, resets and starts a core, then waits for halt.
// Optional RUN watchdog is compiled in with KERNEL_LAUNCHER_TIMEOUT_EN.
module kernel_launcher #(
    parameter int addr_width     = 32,
    parameter int data_width     = 32,
    parameter int timeout_cycles = 65536
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [data_width-1:0] cmd_data,

    output logic                  contr_mem_wr_en,
    output logic [addr_width-1:0] contr_mem_wr_addr,
    output logic [data_width-1:0] contr_mem_wr_data,

    output logic                  contr_core1_clr,
    output logic                  contr_core1_set_pc_req,
    output logic [data_width-1:0] contr_core1_set_pc_addr,
    output logic                  contr_core1_ena,
    input  logic                  contr_core1_halt,

    output logic                  busy,
    output logic                  done,
    output logic                  timed_out,
    output logic                  cmd_err,
    output logic [31:0]           cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SET_PC,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_SET_ADDR = 2'd0;
    localparam logic [1:0] OP_WRITE    = 2'd1;
    localparam logic [1:0] OP_LAUNCH   = 2'd2;

    localparam logic [addr_width-1:0] ADDR_STEP = addr_width'(4);

    state_t                state_q, state_d;
    logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [addr_width-1:0] wr_addr_q, wr_addr_d;
    logic [data_width-1:0] wr_data_q, wr_data_d;
    logic                  wr_en_q, wr_en_d;
    logic [data_width-1:0] pc_q, pc_d;
    logic                  err_q, err_d;
    logic [31:0]           cnt_q, cnt_d;
    logic                  cmd_fire;
    logic [addr_width-1:0] cmd_addr;
    logic                  timeout_hit;

    assign cmd_fire = cmd_valid && (state_q == S_IDLE);

    // Address commands take the low bits of cmd_data, zero-extended if the bus is narrower.
    generate
        if (addr_width <= data_width) begin : g_addr_slice
            assign cmd_addr = cmd_data[addr_width-1:0];
        end else begin : g_addr_ext
            assign cmd_addr = {{(addr_width-data_width){1'b0}}, cmd_data};
        end
    endgenerate

`ifdef KERNEL_LAUNCHER_TIMEOUT_EN
    localparam logic [32:0] TIMEOUT_LIM = 33'(timeout_cycles);

    logic to_q, to_d;

    // The current RUN cycle is the timeout_cycles-th one once it has been counted.
    assign timeout_hit = (state_q == S_RUN) && (({1'b0, cnt_q} + 33'd1) >= TIMEOUT_LIM);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            pc_q      <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
`ifdef KERNEL_LAUNCHER_TIMEOUT_EN
            to_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            pc_q      <= pc_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
`ifdef KERNEL_LAUNCHER_TIMEOUT_EN
            to_q      <= to_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        pc_d      = pc_q;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
`ifdef KERNEL_LAUNCHER_TIMEOUT_EN
        to_d      = to_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_SET_ADDR: wr_ptr_d = cmd_addr;
                        OP_WRITE: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = wr_ptr_q;
                            wr_data_d = cmd_data;
                            wr_ptr_d  = wr_ptr_q + ADDR_STEP;
                        end
                        OP_LAUNCH: begin
                            pc_d    = cmd_data;
                            state_d = S_CLEAR;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_CLEAR: state_d = S_SET_PC;
            S_SET_PC: begin
                state_d = S_RUN;
                cnt_d   = '0;
`ifdef KERNEL_LAUNCHER_TIMEOUT_EN
                to_d    = 1'b0;
`endif
            end
            S_RUN: begin
                if (cnt_q != 32'hFFFF_FFFF) begin
                    cnt_d = cnt_q + 32'd1;
                end
                // A halt seen in the same cycle as the watchdog expiry is a normal completion.
                if (contr_core1_halt) begin
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
`ifdef KERNEL_LAUNCHER_TIMEOUT_EN
                    to_d    = 1'b1;
`endif
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready               = (state_q == S_IDLE);
    assign busy                    = (state_q != S_IDLE);
    assign done                    = (state_q == S_DONE);
    assign cmd_err                 = err_q;
    assign cycle_count             = cnt_q;

    assign contr_mem_wr_en         = wr_en_q;
    assign contr_mem_wr_addr       = wr_addr_q;
    assign contr_mem_wr_data       = wr_data_q;

    assign contr_core1_clr         = (state_q == S_CLEAR);
    assign contr_core1_set_pc_req  = (state_q == S_SET_PC);
    assign contr_core1_set_pc_addr = pc_q;
    assign contr_core1_ena         = (state_q == S_RUN);

`ifdef KERNEL_LAUNCHER_TIMEOUT_EN
    assign timed_out = (state_q == S_DONE) && to_q;
`else
    assign timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_kernel_launcher.sv
// Directed + randomized bench for kernel_launcher with a small behavioural model of the host protocol.
module tb_kernel_launcher;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [DW-1:0] cmd_data = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          clr, set_pc_req, ena;
    logic [DW-1:0] set_pc_addr;
    logic          halt = 1'b0;
    logic          busy, done, timed_out, cmd_err;
    logic [31:0]   cycle_count;

    int tests = 0;
    int fails = 0;
    logic [AW-1:0] model_ptr;

    kernel_launcher #(
        .addr_width(AW), .data_width(DW), .timeout_cycles(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .contr_mem_wr_en(wr_en), .contr_mem_wr_addr(wr_addr), .contr_mem_wr_data(wr_data),
        .contr_core1_clr(clr), .contr_core1_set_pc_req(set_pc_req),
        .contr_core1_set_pc_addr(set_pc_addr), .contr_core1_ena(ena),
        .contr_core1_halt(halt),
        .busy(busy), .done(done), .timed_out(timed_out), .cmd_err(cmd_err),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_excl(input string tag);
        int n;
        n = int'(ena) + int'(clr) + int'(set_pc_req);
        chk(tag, 64'(n <= 1), 64'd1);
    endtask

    task automatic send(input logic [1:0] op, input logic [DW-1:0] data);
        chk("cmd_ready_before_send", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        step();
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_data  = '0;
    endtask

    task automatic set_addr(input logic [AW-1:0] a);
        send(2'd0, a);
        model_ptr = a;
        chk("set_addr_no_write", 64'(wr_en), 64'd0);
        $display("[TB] SET_ADDR 0x%08h", a);
    endtask

    task automatic do_write(input logic [DW-1:0] d);
        logic [AW-1:0] exp_addr;
        exp_addr = model_ptr;
        send(2'd1, d);
        chk("write_en", 64'(wr_en), 64'd1);
        chk("write_addr", 64'(wr_addr), 64'(exp_addr));
        chk("write_data", 64'(wr_data), 64'(d));
        model_ptr = exp_addr + 32'd4;
        $display("[TB] WRITE addr=0x%08h data=0x%08h", exp_addr, d);
    endtask

    // Launch then halt in the run_len-th RUN cycle; checks the whole control sequence.
    task automatic run_launch(input logic [DW-1:0] pc, input int run_len);
        send(2'd2, pc);
        chk("clear_clr", 64'(clr), 64'd1);
        chk("clear_busy", 64'(busy), 64'd1);
        chk("clear_ready", 64'(cmd_ready), 64'd0);
        chk("clear_ena", 64'(ena), 64'd0);
        chk_excl("clear_excl");
        step();
        chk("setpc_req", 64'(set_pc_req), 64'd1);
        chk("setpc_addr", 64'(set_pc_addr), 64'(pc));
        chk("setpc_clr", 64'(clr), 64'd0);
        chk_excl("setpc_excl");
        step();
        for (int i = 0; i < run_len; i++) begin
            chk("run_ena", 64'(ena), 64'd1);
            chk("run_done", 64'(done), 64'd0);
            chk("run_count", 64'(cycle_count), 64'(i));
            chk_excl("run_excl");
            halt = (i == run_len - 1);
            step();
        end
        halt = 1'b0;
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_ena", 64'(ena), 64'd0);
        chk("done_busy", 64'(busy), 64'd1);
        chk("done_timed_out", 64'(timed_out), 64'd0);
        chk("done_count", 64'(cycle_count), 64'(run_len));
        step();
        chk("idle_done", 64'(done), 64'd0);
        chk("idle_ready", 64'(cmd_ready), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_count_hold", 64'(cycle_count), 64'(run_len));
        $display("[TB] LAUNCH pc=0x%08h run_len=%0d count=%0d", pc, run_len, cycle_count);
    endtask

    initial begin
        logic [DW-1:0] d;
        int n;

        // Reset state
        rst = 1'b0;
        step();
        step();
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_clr", 64'(clr), 64'd0);
        chk("rst_setpc", 64'(set_pc_req), 64'd0);
        chk("rst_setpc_addr", 64'(set_pc_addr), 64'd0);
        chk("rst_ena", 64'(ena), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_timed_out", 64'(timed_out), 64'd0);
        chk("rst_err", 64'(cmd_err), 64'd0);
        chk("rst_count", 64'(cycle_count), 64'd0);
        rst = 1'b1;
        model_ptr = '0;
        step();
        $display("[TB] reset released");

        // Back-to-back writes
        set_addr(32'h100);
        do_write(32'hA);
        do_write(32'hB);
        do_write(32'hC);
        step();
        chk("b2b_end_wr_en", 64'(wr_en), 64'd0);

        // Address wrap
        set_addr(32'hFFFF_FFFC);
        do_write($urandom);
        do_write($urandom);
        chk("wrap_addr_zero", 64'(wr_addr), 64'd0);
        step();

        // Random write bursts with occasional idle gaps
        for (int r = 0; r < 4; r++) begin
            set_addr($urandom & 32'hFFFF_FFFC);
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                do_write($urandom);
                if ($urandom_range(0, 2) == 0) begin
                    step();
                    chk("gap_wr_en", 64'(wr_en), 64'd0);
                end
            end
        end
        step();

        // Reserved op: error pulse, pointer untouched
        d = $urandom;
        send(2'd3, d);
        chk("rsv_err", 64'(cmd_err), 64'd1);
        chk("rsv_busy", 64'(busy), 64'd0);
        chk("rsv_wr_en", 64'(wr_en), 64'd0);
        $display("[TB] RESERVED data=0x%08h err=%0d", d, cmd_err);
        step();
        chk("rsv_err_clear", 64'(cmd_err), 64'd0);
        do_write($urandom);

        // Write immediately followed by launch, halt 10 cycles after ena
        do_write(32'h1234_5678);
        run_launch(32'h80, 11);
        step();
        chk("count_hold_idle", 64'(cycle_count), 64'd11);

        // Halt already high in the first RUN cycle
        run_launch($urandom, 1);

        for (int r = 0; r < 3; r++) begin
            run_launch($urandom, $urandom_range(2, 20));
        end

        // Reset mid-RUN
        send(2'd2, 32'h200);
        step();
        step();
        step();
        step();
        chk("pre_rst_ena", 64'(ena), 64'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("midrst_ena", 64'(ena), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(cmd_ready), 64'd1);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_count", 64'(cycle_count), 64'd0);
        chk("midrst_pc", 64'(set_pc_addr), 64'd0);
        $display("[TB] reset during RUN ena=%0d busy=%0d", ena, busy);
        step();
        chk("midrst_no_done", 64'(done), 64'd0);
        model_ptr = '0;
        do_write($urandom);

        // Halt never arrives
        send(2'd2, 32'h300);
        step();
        step();
`ifdef KERNEL_LAUNCHER_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            chk("to_run_ena", 64'(ena), 64'd1);
            chk("to_run_count", 64'(cycle_count), 64'(i));
            step();
        end
        chk("to_done", 64'(done), 64'd1);
        chk("to_timed_out", 64'(timed_out), 64'd1);
        chk("to_count", 64'(cycle_count), 64'(TO));
        step();
        chk("to_idle", 64'(cmd_ready), 64'd1);
        chk("to_timed_out_clear", 64'(timed_out), 64'd0);
        $display("[TB] watchdog expired after %0d cycles", TO);
`else
        for (int i = 0; i < 3 * TO; i++) begin
            chk("nowd_ena", 64'(ena), 64'd1);
            chk("nowd_done", 64'(done), 64'd0);
            chk("nowd_timed_out", 64'(timed_out), 64'd0);
            step();
        end
        $display("[TB] no watchdog: ena still %0d after %0d cycles", ena, 3 * TO);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("nowd_rst_ena", 64'(ena), 64'd0);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
